mem_arbiter: RTL and testbench

- Two-master arbiter and sequencer in front of the main memory bank.
- Requester 0 is the CPU multicycle datapath; requester 1 is a secondary master (DMA / audio / display fetch).
- Selects one requester per transaction, drives the memory's address, byte-enable, write-data and read/write strobes, waits the memory read latency, and returns read data with a one-cycle acknowledge.
- All memory-side outputs are registered, so the memory sees a clean single-cycle strobe.

---
 rtl/mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-master memory arbiter/sequencer: picks one requester per transaction, drives registered
// memory strobes, waits the read latency and returns data with a one-cycle acknowledge.
module mem_arbiter #(
  parameter int unsigned LATENCY    = 1,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic        iCLK,
  input  logic        iRST_n,
  input  logic        iReq0,
  input  logic        iWe0,
  input  logic [31:0] iAddr0,
  input  logic [3:0]  iBe0,
  input  logic [31:0] iWData0,
  output logic        oAck0,
  output logic [31:0] oRData0,
  input  logic        iReq1,
  input  logic        iWe1,
  input  logic [31:0] iAddr1,
  input  logic [3:0]  iBe1,
  input  logic [31:0] iWData1,
  output logic        oAck1,
  output logic [31:0] oRData1,
  output logic [31:0] oMemAddress,
  output logic [3:0]  oMemByteEnable,
  output logic [31:0] oMemWriteData,
  output logic        oMemRead,
  output logic        oMemWrite,
  input  logic [31:0] iMemData,
  output logic        oBusy,
  output logic        oGrant
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StAck} state_e;

  localparam logic [3:0] CntInit = 4'(LATENCY - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        grant_q, grant_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;
  logic        win;
  logic        enter_ack;

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      grant_q  <= 1'b1;  // requester 0 wins the first tie
      we_q     <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    we_d      = we_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    win       = grant_q;
    enter_ack = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (iReq0 || iReq1) begin
          if (iReq0 && iReq1) win = FIXED_PRIO ? 1'b0 : ~grant_q;
          else                win = iReq1;
          grant_d = win;
          we_d    = win ? iWe1    : iWe0;
          addr_d  = win ? iAddr1  : iAddr0;
          be_d    = win ? iBe1    : iBe0;
          wdata_d = win ? iWData1 : iWData0;
          rd_d    = ~we_d;
          wr_d    = we_d;
          cnt_d   = CntInit;
          state_d = StIssue;
        end
      end
      StIssue: begin
        rd_d = 1'b0;
        wr_d = 1'b0;
        if (we_q || (LATENCY == 1)) begin
          enter_ack = 1'b1;
        end else begin
          cnt_d   = cnt_q - 4'd1;
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) enter_ack = 1'b1;
        else               cnt_d = cnt_q - 4'd1;
      end
      StAck: begin
        addr_d  = '0;
        be_d    = '0;
        wdata_d = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Read data is captured on the same edge that raises the acknowledge.
    if (enter_ack) begin
      state_d = StAck;
      ack0_d  = ~grant_q;
      ack1_d  = grant_q;
      if (grant_q) rdata1_d = iMemData;
      else         rdata0_d = iMemData;
    end
  end

  assign oAck0          = ack0_q;
  assign oAck1          = ack1_q;
  assign oRData0        = rdata0_q;
  assign oRData1        = rdata1_q;
  assign oMemAddress    = addr_q;
  assign oMemByteEnable = be_q;
  assign oMemWriteData  = wdata_q;
  assign oMemRead       = rd_q;
  assign oMemWrite      = wr_q;
  assign oBusy          = (state_q != StIdle);
  assign oGrant         = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: two instances (LATENCY=1 round-robin, LATENCY=3 fixed
// priority) checked every cycle against a transaction-schedule reference model.
module tb_mem_arbiter;

  localparam int NI = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [NI-1:0] req0, req1, we0, we1, ack0, ack1, mrd, mwr, busy, gnt;
  logic [31:0]   addr0 [NI];
  logic [31:0]   addr1 [NI];
  logic [31:0]   wd0   [NI];
  logic [31:0]   wd1   [NI];
  logic [31:0]   rdat0 [NI];
  logic [31:0]   rdat1 [NI];
  logic [31:0]   maddr [NI];
  logic [31:0]   mwd   [NI];
  logic [31:0]   mdata [NI];
  logic [3:0]    be0   [NI];
  logic [3:0]    be1   [NI];
  logic [3:0]    mbe   [NI];

  mem_arbiter #(.LATENCY(1), .FIXED_PRIO(1'b0)) u_dut_a (
    .iCLK(clk), .iRST_n(rst_n),
    .iReq0(req0[0]), .iWe0(we0[0]), .iAddr0(addr0[0]), .iBe0(be0[0]), .iWData0(wd0[0]),
    .oAck0(ack0[0]), .oRData0(rdat0[0]),
    .iReq1(req1[0]), .iWe1(we1[0]), .iAddr1(addr1[0]), .iBe1(be1[0]), .iWData1(wd1[0]),
    .oAck1(ack1[0]), .oRData1(rdat1[0]),
    .oMemAddress(maddr[0]), .oMemByteEnable(mbe[0]), .oMemWriteData(mwd[0]),
    .oMemRead(mrd[0]), .oMemWrite(mwr[0]), .iMemData(mdata[0]),
    .oBusy(busy[0]), .oGrant(gnt[0])
  );

  mem_arbiter #(.LATENCY(3), .FIXED_PRIO(1'b1)) u_dut_b (
    .iCLK(clk), .iRST_n(rst_n),
    .iReq0(req0[1]), .iWe0(we0[1]), .iAddr0(addr0[1]), .iBe0(be0[1]), .iWData0(wd0[1]),
    .oAck0(ack0[1]), .oRData0(rdat0[1]),
    .iReq1(req1[1]), .iWe1(we1[1]), .iAddr1(addr1[1]), .iBe1(be1[1]), .iWData1(wd1[1]),
    .oAck1(ack1[1]), .oRData1(rdat1[1]),
    .oMemAddress(maddr[1]), .oMemByteEnable(mbe[1]), .oMemWriteData(mwd[1]),
    .oMemRead(mrd[1]), .oMemWrite(mwr[1]), .iMemData(mdata[1]),
    .oBusy(busy[1]), .oGrant(gnt[1])
  );

  // Reference model: each transaction is a schedule (grant cycle, ack cycle) plus its fields.
  int          lat   [NI] = '{1, 3};
  bit          fp    [NI] = '{1'b0, 1'b1};
  bit          has_t [NI];
  int          g_c   [NI];
  int          ack_c [NI];
  logic        t_w   [NI];
  logic        t_we  [NI];
  logic [31:0] t_addr[NI];
  logic [31:0] t_wd  [NI];
  logic [3:0]  t_be  [NI];
  logic        last  [NI];
  logic [31:0] e_rd  [NI][2];
  logic [31:0] mem_prev [NI];

  int cyc;
  int total;
  int bad;
  bit do_assert;
  bit do_release;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @cyc%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_cycle(input int k);
    bit          inflight;
    bit          is_ack;
    logic        w;
    logic [31:0] e_addr;
    logic [35:0] e_bewd;
    logic [5:0]  e_ctl;
    if (!rst_n) begin
      has_t[k]   = 1'b0;
      last[k]    = 1'b1;
      e_rd[k][0] = '0;
      e_rd[k][1] = '0;
    end
    inflight = has_t[k] && (cyc > g_c[k]) && (cyc <= ack_c[k]);
    is_ack   = inflight && (cyc == ack_c[k]);
    if (is_ack) e_rd[k][t_w[k]] = mem_prev[k];
    e_addr = inflight ? t_addr[k] : 32'h0;
    e_bewd = inflight ? {t_be[k], t_wd[k]} : 36'h0;
    e_ctl  = {inflight, last[k],
              inflight && (cyc == g_c[k] + 1) && !t_we[k],
              inflight && (cyc == g_c[k] + 1) && t_we[k],
              is_ack && !t_w[k], is_ack && t_w[k]};
    chk($sformatf("i%0d.addr", k), 64'(maddr[k]), 64'(e_addr));
    chk($sformatf("i%0d.be_wdata", k), 64'({mbe[k], mwd[k]}), 64'(e_bewd));
    chk($sformatf("i%0d.busy_gnt_rd_wr_ack0_ack1", k),
        64'({busy[k], gnt[k], mrd[k], mwr[k], ack0[k], ack1[k]}), 64'(e_ctl));
    chk($sformatf("i%0d.rdata0_rdata1", k), {rdat0[k], rdat1[k]}, {e_rd[k][0], e_rd[k][1]});
    mem_prev[k] = mdata[k];
    if (rst_n && !inflight && (req0[k] || req1[k])) begin
      if (req0[k] && req1[k]) w = fp[k] ? 1'b0 : ~last[k];
      else                    w = req1[k];
      t_w[k]    = w;
      t_we[k]   = w ? we1[k]   : we0[k];
      t_addr[k] = w ? addr1[k] : addr0[k];
      t_be[k]   = w ? be1[k]   : be0[k];
      t_wd[k]   = w ? wd1[k]   : wd0[k];
      g_c[k]    = cyc;
      ack_c[k]  = cyc + (t_we[k] ? 2 : 1 + lat[k]);
      has_t[k]  = 1'b1;
      last[k]   = w;
    end
  endtask

  // mode 0: random, 1: both always request, 2: only requester 1, 3: requester 1 held high
  task automatic drive(input int k, input int mode);
    bit busy_r [2];
    bit r_req  [2];
    for (int r = 0; r < 2; r++) begin
      busy_r[r] = has_t[k] && (cyc <= ack_c[k]) && (t_w[k] == r[0]);
      case (mode)
        1:       r_req[r] = 1'b1;
        2:       r_req[r] = busy_r[r] || ((r == 1) && ($urandom_range(0, 2) != 0));
        3:       r_req[r] = busy_r[r] || (r == 1);
        default: r_req[r] = busy_r[r] || ($urandom_range(0, 2) != 0);
      endcase
    end
    req0[k]  = r_req[0];
    req1[k]  = r_req[1];
    we0[k]   = 1'($urandom_range(0, 1));
    we1[k]   = 1'($urandom_range(0, 1));
    addr0[k] = $urandom;
    addr1[k] = $urandom;
    be0[k]   = 4'($urandom_range(0, 15));
    be1[k]   = 4'($urandom_range(0, 15));
    wd0[k]   = $urandom;
    wd1[k]   = $urandom;
    mdata[k] = $urandom;
  endtask

  task automatic step(input int mode);
    @(posedge clk);
    cyc++;
    #1;
    if (do_release) begin
      rst_n      = 1'b1;
      do_release = 1'b0;
    end
    for (int k = 0; k < NI; k++) drive(k, mode);
    if (do_assert) begin
      #1;
      rst_n     = 1'b0;
      do_assert = 1'b0;
      #1;
      chk("rst_async_b", 64'({busy[1], mrd[1], mwr[1], ack0[1], ack1[1], gnt[1]}), 64'h1);
      chk("rst_async_b_bus", 64'(maddr[1] | mwd[1] | rdat0[1] | rdat1[1]), 64'h0);
    end
    @(negedge clk);
    for (int k = 0; k < NI; k++) model_cycle(k);
  endtask

  initial begin
    bit found;
    total      = 0;
    bad        = 0;
    cyc        = 0;
    do_assert  = 1'b0;
    do_release = 1'b0;
    found      = 1'b0;
    for (int k = 0; k < NI; k++) begin
      req0[k] = 1'b0; req1[k] = 1'b0; we0[k] = 1'b0; we1[k] = 1'b0;
      addr0[k] = '0; addr1[k] = '0; be0[k] = '0; be1[k] = '0;
      wd0[k] = '0; wd1[k] = '0; mdata[k] = '0; mem_prev[k] = '0;
      has_t[k] = 1'b0; g_c[k] = 0; ack_c[k] = 0; t_w[k] = 1'b0; t_we[k] = 1'b0;
      t_addr[k] = '0; t_wd[k] = '0; t_be[k] = '0; last[k] = 1'b1;
      e_rd[k][0] = '0; e_rd[k][1] = '0;
    end
    #1 rst_n = 1'b0;
    repeat (3) step(0);
    do_release = 1'b1;
    repeat (300) step(0);
    repeat (40) step(1);
    repeat (30) step(2);

    // Find a read on instance B about to sit in WAIT, then reset in that cycle.
    for (int i = 0; i < 200 && !found; i++) begin
      step(0);
      if (has_t[1] && !t_we[1] && (cyc + 1 == g_c[1] + 2)) found = 1'b1;
    end
    chk("rst_in_wait_found", 64'(found), 64'h1);
    if (found) begin
      do_assert = 1'b1;
      step(3);
      repeat (2) step(3);
      do_release = 1'b1;
      step(3);
      step(3);
      chk("post_rst_grant_b", 64'({gnt[1], mrd[1] | mwr[1]}), 64'h3);
    end else begin
      do_release = 1'b1;
      step(0);
    end
    repeat (200) step(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
